// File: rtl/downsampler.sv
// ---------------------------------------------------------------------------
// downsampler
//
// Integrate-and-dump decimator. Sums 2^k accepted input samples
// (k = decim_log2, latched when a frame opens) and emits one averaged,
// round-half-up, width-converted sample per frame.
//
// Ports:
//   clk         system clock, rising-edge
//   reset       synchronous active-high reset; discards the open frame and
//               any dump already in flight
//   in          signed input sample, qualified by in_valid
//   in_valid    input strobe; may be continuous or sparse
//   decim_log2  decimation exponent k (N = 2^k); sampled only at frame start
//   out         signed averaged output; holds between strobes
//   out_valid   one-cycle strobe per completed frame
//
// Pipeline:
//   edge t   : input sample registered (sample accepted)
//   edge t+1 : accumulate / frame completion, completed sum -> dump register
//   edge t+2 : round, shift, width convert, saturate -> out, out_valid
// ---------------------------------------------------------------------------
module downsampler #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [INPUT_WIDTH-1:0]  in,
    input  logic                           in_valid,
    input  logic        [3:0]              decim_log2,
    output logic signed [OUTPUT_WIDTH-1:0] out,
    output logic                           out_valid
);

    // 15 headroom bits cover a sum of up to 2^15 full-scale samples.
    localparam int ACC_W = INPUT_WIDTH + 15;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Input register
    logic signed [INPUT_WIDTH-1:0]  in_q, in_d;
    logic                           in_valid_q, in_valid_d;
    logic        [3:0]              k_in_q, k_in_d;

    // Frame accumulator
    state_t                         state_q, state_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic        [14:0]             count_q, count_d;
    logic        [3:0]              k_lat_q, k_lat_d;

    // Stage 1: dump register
    logic signed [ACC_W-1:0]        dump_q, dump_d;
    logic        [3:0]              dump_k_q, dump_k_d;
    logic                           dump_valid_q, dump_valid_d;

    // Stage 2: output register
    logic signed [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]        in_ext;
    logic signed [ACC_W-1:0]        sum_next;
    logic        [14:0]             last_cnt;
    logic signed [ACC_W-1:0]        round_term;
    logic signed [ACC_W-1:0]        rounded;
    logic signed [INPUT_WIDTH-1:0]  avg;
    logic signed [OUTPUT_WIDTH-1:0] conv;

    assign out       = out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        in_d       = in;
        in_valid_d = in_valid;
        k_in_d     = decim_log2;
    end

    // Frame control. The index of the last sample is derived from the
    // latched exponent so a mid-frame decim_log2 change cannot move it.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        k_lat_d      = k_lat_q;
        dump_d       = dump_q;
        dump_k_d     = dump_k_q;
        dump_valid_d = 1'b0;

        in_ext   = {{15{in_q[INPUT_WIDTH-1]}}, in_q};
        sum_next = acc_q + in_ext;
        last_cnt = 15'((16'd1 << k_lat_q) - 16'd1);

        case (state_q)
            IDLE: begin
                if (in_valid_q) begin
                    k_lat_d = k_in_q;
                    if (k_in_q == 4'd0) begin
                        // N = 1: every sample is a whole frame.
                        dump_d       = in_ext;
                        dump_k_d     = 4'd0;
                        dump_valid_d = 1'b1;
                    end else begin
                        acc_d   = in_ext;
                        count_d = 15'd1;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid_q) begin
                    if (count_q == last_cnt) begin
                        dump_d       = sum_next;
                        dump_k_d     = k_lat_q;
                        dump_valid_d = 1'b1;
                        acc_d        = '0;
                        count_d      = 15'd0;
                        state_d      = IDLE;
                    end else begin
                        acc_d   = sum_next;
                        count_d = count_q + 15'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Average with round-half-up; the quotient always fits INPUT_WIDTH bits.
    always_comb begin
        round_term = (dump_k_q == 4'd0) ? '0 : (ACC_W'(1) << (dump_k_q - 4'd1));
        rounded    = dump_q + round_term;
        avg        = INPUT_WIDTH'(rounded >>> dump_k_q);
    end

    generate
        if (OUTPUT_WIDTH >= INPUT_WIDTH) begin : g_widen
            localparam int SH = OUTPUT_WIDTH - INPUT_WIDTH;
            always_comb begin
                conv = $signed(OUTPUT_WIDTH'(avg)) <<< SH;
            end
        end else begin : g_narrow
            localparam int D = INPUT_WIDTH - OUTPUT_WIDTH;
            localparam logic signed [INPUT_WIDTH:0] HALF =
                {{INPUT_WIDTH{1'b0}}, 1'b1} << (D - 1);
            localparam logic signed [INPUT_WIDTH:0] MAXV =
                {{(D + 2){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
            logic signed [INPUT_WIDTH:0] ext;
            logic signed [INPUT_WIDTH:0] rnd;
            // One extra bit keeps the rounding add from wrapping; only the
            // positive extreme can exceed the output range.
            always_comb begin
                ext  = {avg[INPUT_WIDTH-1], avg};
                rnd  = (ext + HALF) >>> D;
                conv = (rnd > MAXV) ? MAXV[OUTPUT_WIDTH-1:0] : rnd[OUTPUT_WIDTH-1:0];
            end
        end
    endgenerate

    always_comb begin
        out_d       = dump_valid_q ? conv : out_q;
        out_valid_d = dump_valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q         <= '0;
            in_valid_q   <= 1'b0;
            k_in_q       <= 4'd0;
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= 15'd0;
            k_lat_q      <= 4'd0;
            dump_q       <= '0;
            dump_k_q     <= 4'd0;
            dump_valid_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            in_q         <= in_d;
            in_valid_q   <= in_valid_d;
            k_in_q       <= k_in_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            k_lat_q      <= k_lat_d;
            dump_q       <= dump_d;
            dump_k_q     <= dump_k_d;
            dump_valid_q <= dump_valid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_downsampler.sv
// ---------------------------------------------------------------------------
// tb_downsampler
//
// Two instances: dut_a widens 16 -> 24 bits, dut_b narrows 16 -> 12 bits.
// Drivers push {expected value, expected strobe cycle} into a per-DUT queue
// when they issue a frame's last sample; monitors pop and compare on every
// out_valid. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_downsampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic signed [15:0] in_a, in_b;
    logic               in_valid_a, in_valid_b;
    logic        [3:0]  decim_a, decim_b;
    logic signed [23:0] out_a;
    logic               out_valid_a;
    logic signed [11:0] out_b;
    logic               out_valid_b;

    downsampler #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(24)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .in_valid(in_valid_a),
        .decim_log2(decim_a), .out(out_a), .out_valid(out_valid_a)
    );

    downsampler #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(12)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid_b),
        .decim_log2(decim_b), .out(out_b), .out_valid(out_valid_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // sel 0 -> dut_a, 1 -> dut_b. Sample is captured at the next rising
    // edge (cyc+1); its strobe is expected two edges later.
    task automatic drive(input int sel, input int v, input bit last, input int expv);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            in_a = 16'(v);
            in_valid_a = 1'b1;
        end else begin
            in_b = 16'(v);
            in_valid_b = 1'b1;
        end
        if (last) begin
            e.val = expv;
            e.cyc = cyc + 3;
            if (sel == 0) q_a.push_back(e);
            else q_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid_a = 1'b0;
            in_valid_b = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (out_valid_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_a: unexpected strobe out=%0d at cycle %0d, expected none", out_a, cyc);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("out_a", int'(out_a), e.val);
                check("strobe_cycle_a", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_b: unexpected strobe out=%0d at cycle %0d, expected none", out_b, cyc);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("out_b", int'(out_b), e.val);
                check("strobe_cycle_b", cyc, e.cyc);
            end
        end
    end

    initial begin
        int v4[4];
        reset      = 1'b1;
        in_a       = '0;
        in_b       = '0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        decim_a    = 4'd2;
        decim_b    = 4'd0;
        v4         = '{4, 8, 12, 16};

        repeat (3) @(negedge clk);
        check("reset_out_a", int'(out_a), 0);
        check("reset_valid_a", int'(out_valid_a), 0);
        check("reset_out_b", int'(out_b), 0);
        check("reset_valid_b", int'(out_valid_b), 0);
        reset = 1'b0;

        // k=2, constant 100: avg 100, widened by 8 bits -> 25600 every 4th.
        decim_a = 4'd2;
        for (int i = 0; i < 8; i++) drive(0, 100, (i % 4) == 3, 25600);
        idle(1);

        // k=1: (1+2+1)>>1=2 -> 512; (-3+1)>>>1=-1 -> -256.
        decim_a = 4'd1;
        drive(0, 1, 1'b0, 0);
        drive(0, 2, 1'b1, 512);
        drive(0, -1, 1'b0, 0);
        drive(0, -2, 1'b1, -256);
        idle(1);

        // k=2 sparse: (40+2)>>2=10 -> 2560, then out must hold.
        decim_a = 4'd2;
        for (int i = 0; i < 4; i++) begin
            drive(0, v4[i], i == 3, 2560);
            idle(2);
        end
        idle(6);
        check("hold_out_a", int'(out_a), 2560);
        check("hold_valid_a", int'(out_valid_a), 0);

        // k changes 2->3 mid-frame: frame closes after 4 (102>>2=25 -> 6400),
        // next frame 1..8: (36+4)>>3=5 -> 1280.
        decim_a = 4'd2;
        drive(0, 10, 1'b0, 0);
        drive(0, 20, 1'b0, 0);
        decim_a = 4'd3;
        drive(0, 30, 1'b0, 0);
        drive(0, 40, 1'b1, 6400);
        for (int i = 1; i <= 8; i++) drive(0, i, i == 8, 1280);
        idle(1);

        // Reset after 3 of 4 samples, then reset right after a last sample.
        decim_a = 4'd2;
        for (int i = 0; i < 3; i++) drive(0, v4[i], 1'b0, 0);
        @(negedge clk);
        in_valid_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(0, v4[i], 1'b0, 0);
        @(negedge clk);
        in_valid_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        check("post_reset_out_a", int'(out_a), 0);
        check("post_reset_valid_a", int'(out_valid_a), 0);

        // Clean frame after the resets.
        for (int i = 0; i < 4; i++) drive(0, v4[i], i == 3, 2560);
        idle(1);

        // dut_b, k=0, back-to-back: saturation, negative full scale, rounding.
        drive(1, 32767, 1'b1, 2047);
        drive(1, -32768, 1'b1, -2048);
        drive(1, 24, 1'b1, 2);
        idle(1);

        for (int w = 0; w < 50 && (q_a.size() != 0 || q_b.size() != 0); w++) @(negedge clk);
        while (q_a.size() != 0) begin
            exp_t e;
            e = q_a.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_strobe_a: no strobe seen, expected out=%0d at cycle %0d", e.val, e.cyc);
        end
        while (q_b.size() != 0) begin
            exp_t e;
            e = q_b.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_strobe_b: no strobe seen, expected out=%0d at cycle %0d", e.val, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
